// File: rtl/dmem_stage_mp.sv
// N-port data-memory pipeline stage: request register, shared word array access, registered response.
// Optional macro DMEM_STAGE_WRITE_FIRST_EN: same-cycle load/store to one index returns the new data.
module dmem_stage_mp #(
  parameter int NPORT  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_we,
  input  logic [NPORT*32-1:0]     req_addr,
  input  logic [NPORT*DATA_W-1:0] req_din,
  input  logic [NPORT*TAG_W-1:0]  req_tag,
  output logic [NPORT-1:0]        rsp_valid,
  output logic [NPORT*DATA_W-1:0] rsp_dout,
  output logic [NPORT*TAG_W-1:0]  rsp_tag,
  output logic                    oob_err,
  output logic [CNT_W-1:0]        coll_cnt
);

  localparam int HI_W = 30 - ADDR_W;

  logic [DATA_W-1:0] mem_array [0:(1<<ADDR_W)-1];

  logic [NPORT-1:0]                   s1_valid_q, s1_valid_d;
  logic [NPORT-1:0]                   s1_we_q, s1_we_d;
  logic [NPORT-1:0]                   s1_oob_q, s1_oob_d;
  logic [NPORT-1:0][ADDR_W-1:0]       s1_idx_q, s1_idx_d;
  logic [NPORT-1:0][DATA_W-1:0]       s1_din_q, s1_din_d;
  logic [NPORT-1:0][TAG_W-1:0]        s1_tag_q, s1_tag_d;
  logic [NPORT-1:0]                   s2_valid_q, s2_valid_d;
  logic [NPORT-1:0][DATA_W-1:0]       s2_dout_q, s2_dout_d;
  logic [NPORT-1:0][TAG_W-1:0]        s2_tag_q, s2_tag_d;
  logic [NPORT-1:0]                   rsp_valid_q, rsp_valid_d;
  logic [NPORT-1:0][DATA_W-1:0]       rsp_dout_q, rsp_dout_d;
  logic [NPORT-1:0][TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
  logic                               oob_err_q, oob_err_d;
  logic [CNT_W-1:0]                   coll_cnt_q, coll_cnt_d;

  logic [NPORT-1:0]                   wr_ok;
  logic [NPORT-1:0][DATA_W-1:0]       rd_data;
  logic                               coll;
  logic                               unused_addr_lo;

  assign wr_ok = s1_valid_q & s1_we_q & ~s1_oob_q;

  // Array read for the S2 slot; write-first build forwards same-cycle store data, highest port last.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_data[p] = mem_array[s1_idx_q[p]];
`ifdef DMEM_STAGE_WRITE_FIRST_EN
      for (int q = 0; q < NPORT; q++) begin
        if (wr_ok[q] && (s1_idx_q[q] == s1_idx_q[p])) begin
          rd_data[p] = s1_din_q[q];
        end
      end
`endif
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      for (int j = i + 1; j < NPORT; j++) begin
        if (wr_ok[i] && wr_ok[j] && (s1_idx_q[i] == s1_idx_q[j])) begin
          coll = 1'b1;
        end
      end
    end
  end

  always_comb begin
    unused_addr_lo = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      unused_addr_lo = unused_addr_lo ^ (^req_addr[p*32 +: 2]);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_we_d     = s1_we_q;
    s1_oob_d    = s1_oob_q;
    s1_idx_d    = s1_idx_q;
    s1_din_d    = s1_din_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_dout_d   = s2_dout_q;
    s2_tag_d    = s2_tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dout_d  = rsp_dout_q;
    rsp_tag_d   = rsp_tag_q;
    oob_err_d   = oob_err_q;
    coll_cnt_d  = coll_cnt_q;
    if (!stall) begin
      for (int p = 0; p < NPORT; p++) begin
        s1_valid_d[p] = req_valid[p];
        s1_we_d[p]    = req_we[p];
        s1_idx_d[p]   = req_addr[p*32+2 +: ADDR_W];
        s1_oob_d[p]   = |req_addr[p*32+ADDR_W+2 +: HI_W];
        s1_din_d[p]   = req_din[p*DATA_W +: DATA_W];
        s1_tag_d[p]   = req_tag[p*TAG_W +: TAG_W];
        // Stores and out-of-range loads respond with zero data.
        s2_dout_d[p]  = (s1_valid_q[p] && !s1_we_q[p] && !s1_oob_q[p]) ? rd_data[p] : '0;
      end
      s2_valid_d  = s1_valid_q;
      s2_tag_d    = s1_tag_q;
      rsp_valid_d = s2_valid_q;
      rsp_dout_d  = s2_dout_q;
      rsp_tag_d   = s2_tag_q;
      oob_err_d   = oob_err_q | (|(s1_valid_q & s1_oob_q));
      if (coll && (coll_cnt_q != {CNT_W{1'b1}})) begin
        coll_cnt_d = coll_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= '0;
      s1_we_q     <= '0;
      s1_oob_q    <= '0;
      s1_idx_q    <= '0;
      s1_din_q    <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= '0;
      s2_dout_q   <= '0;
      s2_tag_q    <= '0;
      rsp_valid_q <= '0;
      rsp_dout_q  <= '0;
      rsp_tag_q   <= '0;
      oob_err_q   <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_we_q     <= s1_we_d;
      s1_oob_q    <= s1_oob_d;
      s1_idx_q    <= s1_idx_d;
      s1_din_q    <= s1_din_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_dout_q   <= s2_dout_d;
      s2_tag_q    <= s2_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_tag_q   <= rsp_tag_d;
      oob_err_q   <= oob_err_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  // Ascending port order makes the highest-numbered port win a same-index store collision.
  always_ff @(posedge clk) begin
    if (!rst && !stall) begin
      for (int p = 0; p < NPORT; p++) begin
        if (wr_ok[p]) begin
          mem_array[s1_idx_q[p]] <= s1_din_q[p];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_tag   = rsp_tag_q;
  assign oob_err   = oob_err_q;
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: doc/dmem_stage_mp.md
Name: dmem_stage_mp

Overview:
- Parametrised N-port data-memory pipeline stage for the 2nd-generation core.
- Sits between EX and WB. Accepts one load/store per port per cycle, accesses a shared word-addressed array, and returns load data with fixed 2-cycle latency.
- Carries a per-port tag (destination register) alongside each request.
- Adds over the previous dual-port stage: a single-edge (posedge-only) design, deterministic write-collision resolution, out-of-range detection, and a collision counter.

Parameters:
- NPORT, 2, number of independent access ports (1..4)
- DATA_W, 32, data word width
- ADDR_W, 17, word-index width; array depth = 2**ADDR_W words
- TAG_W, 5, width of per-port pass-through tag
- CNT_W, 16, collision counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  global interlock; 1 = freeze whole stage
- req_valid  in  NPORT  request valid per port
- req_we  in  NPORT  1 = store, 0 = load
- req_addr  in  NPORT*32  byte address per port; word index = addr[ADDR_W+1:2]
- req_din  in  NPORT*DATA_W  store data
- req_tag  in  NPORT*TAG_W  tag passed through
- rsp_valid  out  NPORT  response valid (loads and stores)
- rsp_dout  out  NPORT*DATA_W  load data; 0 for stores
- rsp_tag  out  NPORT*TAG_W  tag of the responding request
- oob_err  out  1  sticky: some request had addr[31:ADDR_W+2] != 0
- coll_cnt  out  CNT_W  count of cycles with a same-address store collision

Behaviour:
- Reset values: rsp_valid=0, rsp_dout=0, rsp_tag=0, oob_err=0, coll_cnt=0, all internal valids=0. Array contents are NOT cleared.
- Pipeline stages:
  - S1 (edge E0): request registered when stall=0.
  - S2 (edge E1): array written and read.
  - Output: registered result visible after edge E2. Latency = 2 un-stalled edges from acceptance.
- stall=1: every pipeline register holds its value, no array write occurs, and rsp_* hold. Requests presented during stall are not accepted; the producer holds them.
- A port with req_valid=0 propagates a bubble: rsp_valid=0 for that port and the slot.
- Store: writes req_din to the word index. rsp_valid=1 and rsp_dout=0 at output time.
- Load: rsp_dout = array word. Read-first by default: a load and a store to the same index in the same S2 cycle return the old value.
- Store/store collision (two or more ports, same index, same S2 cycle): the highest-numbered port's data is written. coll_cnt increments by 1 per such cycle (not per pair) and saturates at all-ones.
- Out-of-range address (upper bits nonzero):
  - store is dropped (no write);
  - load returns 0;
  - rsp_valid is still 1;
  - oob_err sets and stays set until rst.
- Address bits [1:0] are ignored (word access only).
- rst asserted mid-operation: in-flight S1/S2 requests are discarded and their stores are not written, even if stall=0. rst has priority over stall.
- Back-to-back traffic: one request per port per cycle sustained, with no bubbles inserted.
- Store then load, same address, consecutive cycles: the load sees the stored value, because the store commits at E1 before the load reaches S2.

Optional Feature:
- Macro: DMEM_STAGE_WRITE_FIRST_EN.
- Defined: a same-cycle load/store to the same index returns the new data. With multiple stores to that index, the load returns the highest-numbered port's data, matching the collision rule.
- Undefined: read-first (old data), as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then port0 store 0x0000_0010←0xDEADBEEF. Next cycle, port1 load 0x10 → port1 rsp_valid=1, rsp_dout=0xDEADBEEF, tag echoed, exactly 2 edges after acceptance.
- Same cycle: port0 store 0x20←0x11111111 and port1 store 0x20←0x22222222. Later load 0x20 → 0x22222222; coll_cnt=1.
- Memory[0x30]=0xAAAA0000. Same cycle: port0 load 0x30 and port1 store 0x30←0x5555. Port0 gets 0xAAAA0000 (default) or 0x00005555 (WRITE_FIRST_EN).
- Store to 0x0008_0000 with ADDR_W=17 → no write (word 0 unchanged); oob_err=1, and it stays 1 after 10 further valid requests. Load of the same address → rsp_dout=0.
- Accept a store, then hold stall=1 for 3 cycles → rsp_* frozen and array unchanged. Release → store commits and responds on the next edges.
- Accept a store to 0x40←0x1234, then assert rst on the next edge → rsp_valid=0 and word 0x40 keeps its prior value.
